// File: rtl/nvme_pcie_req_sequencer.sv
// nvme_pcie_req_sequencer
// Feeds the PCIe master pulse interface from two sources: a FIFO of NVMe
// doorbell writes and a single held host register request. One transaction
// is in flight at a time; register requests take priority over doorbells.
// A missing completion halts the block until reset.
module nvme_pcie_req_sequencer #(
   parameter int          FIFO_DEPTH     = 8,
   parameter logic [31:0] DB_BASE        = 32'h1000,
   parameter int          DSTRD          = 0,
   parameter int          TIMEOUT_CYCLES = 4096
) (
   input  logic                          axi_aclk,
   input  logic                          axi_areset,
   input  logic                          db_valid,
   output logic                          db_ready,
   input  logic [3:0]                    db_qid,
   input  logic                          db_is_cq,
   input  logic [15:0]                   db_value,
   output logic [$clog2(FIFO_DEPTH):0]   db_count,
   output logic                          db_error,
   input  logic                          reg_req,
   input  logic                          reg_wr,
   input  logic [31:0]                   reg_addr,
   input  logic [31:0]                   reg_wdata,
   output logic                          reg_busy,
   output logic                          reg_done,
   output logic [31:0]                   reg_rdata,
   output logic                          reg_error,
   output logic                          pcie_write,
   output logic [31:0]                   pcie_waddr,
   output logic [31:0]                   pcie_wdata,
   input  logic                          pcie_wdone,
   input  logic                          pcie_werror,
   output logic                          pcie_read,
   output logic [31:0]                   pcie_raddr,
   input  logic [31:0]                   pcie_rdata,
   input  logic                          pcie_rdone,
   input  logic                          pcie_rerror,
   output logic                          fatal
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HALT
   } state_t;

   state_t state, state_n;

   // Doorbell FIFO: each entry keeps {qid, is_cq, value}; the address is
   // formed when the entry is popped.
   logic [20:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [20:0]   head;
   logic [31:0]   head_off;
   logic          push, pop;

   // Held register request.
   logic          reg_pend;
   logic          reg_wr_q;
   logic [31:0]   reg_addr_q;
   logic [31:0]   reg_wdata_q;
   logic          accept;

   // Transaction currently being issued / awaited.
   logic          cur_is_reg;
   logic          cur_wr;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_data;
   logic [TW-1:0] tcount;

   logic          load_reg;
   logic          xact_done;

   assign head     = mem[rd_ptr];
   assign head_off = {27'd0, head[20:17], head[16]} << (2 + DSTRD);

   assign db_ready = !axi_areset && (db_count < CW'(FIFO_DEPTH)) && !fatal;
   assign push     = db_valid && db_ready;
   assign reg_busy = reg_pend || reg_done;
   assign accept   = reg_req && !reg_busy;

   assign pcie_waddr = cur_addr;
   assign pcie_wdata = cur_data;
   assign pcie_raddr = cur_addr;

   // State register.
   // NOTE: every clocked block uses non-blocking (<=) assignments so all
   // registers update together from pre-edge values, independent of block order.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) state <= S_IDLE;
      else            state <= state_n;
   end

   // Next-state decode and the pulse outputs of the sequencer.
   // NOTE: every output of this block gets a default first so no path leaves
   // a value unassigned, which would infer a latch.
   always_comb begin
      state_n    = state;
      pop        = 1'b0;
      load_reg   = 1'b0;
      xact_done  = 1'b0;
      pcie_write = 1'b0;
      pcie_read  = 1'b0;
      fatal      = 1'b0;
      case (state)
         S_IDLE: begin
            if (reg_pend) begin
               load_reg = 1'b1;
               state_n  = S_ISSUE;
            end else if (db_count != '0) begin
               pop     = 1'b1;
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            pcie_write = cur_wr;
            pcie_read  = !cur_wr;
            state_n    = S_WAIT;
         end
         S_WAIT: begin
            if (cur_wr ? pcie_wdone : pcie_rdone) begin
               xact_done = 1'b1;
               state_n   = S_IDLE;
            end else if (tcount == TW'(TIMEOUT_CYCLES - 2)) begin
               state_n = S_HALT;
            end
         end
         S_HALT: begin
            fatal = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Doorbell storage writes.
   // NOTE: the storage array is deliberately not reset; occupancy is tracked
   // by the reset pointers and count, so stale entries are never read.
   always_ff @(posedge axi_aclk) begin
      if (push) mem[wr_ptr] <= {db_qid, db_is_cq, db_value};
   end

   // FIFO pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         db_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   db_count <= db_count + CW'(1);
            2'b01:   db_count <= db_count - CW'(1);
            default: db_count <= db_count;
         endcase
      end
   end

   // Capture the transaction being issued and run the response timer.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         cur_is_reg <= 1'b0;
         cur_wr     <= 1'b0;
         cur_addr   <= '0;
         cur_data   <= '0;
         tcount     <= '0;
      end else begin
         if (load_reg) begin
            cur_is_reg <= 1'b1;
            cur_wr     <= reg_wr_q;
            cur_addr   <= reg_addr_q;
            cur_data   <= reg_wdata_q;
         end else if (pop) begin
            cur_is_reg <= 1'b0;
            cur_wr     <= 1'b1;
            cur_addr   <= DB_BASE + head_off;
            cur_data   <= {16'h0, head[15:0]};
         end
         if (state == S_ISSUE)     tcount <= '0;
         else if (state == S_WAIT) tcount <= tcount + TW'(1);
      end
   end

   // Register request holding and completion / error reporting.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         reg_pend    <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_done    <= 1'b0;
         reg_rdata   <= '0;
         reg_error   <= 1'b0;
         db_error    <= 1'b0;
      end else begin
         reg_done <= 1'b0;
         db_error <= 1'b0;
         if (fatal) begin
            // Halted: any held or new register request is refused at once.
            if (reg_pend) begin
               reg_done  <= 1'b1;
               reg_error <= 1'b1;
               reg_pend  <= 1'b0;
            end else if (accept) begin
               reg_done  <= 1'b1;
               reg_error <= 1'b1;
            end
         end else begin
            if (accept) begin
               reg_pend    <= 1'b1;
               reg_wr_q    <= reg_wr;
               reg_addr_q  <= reg_addr;
               reg_wdata_q <= reg_wdata;
            end
            if (xact_done && cur_is_reg) begin
               reg_done  <= 1'b1;
               reg_pend  <= 1'b0;
               reg_error <= cur_wr ? pcie_werror : pcie_rerror;
               if (!cur_wr) reg_rdata <= pcie_rdata;
            end
            if (xact_done && !cur_is_reg) db_error <= pcie_werror;
         end
      end
   end

endmodule

// File: tb/tb_nvme_pcie_req_sequencer.sv
// Self-checking bench for nvme_pcie_req_sequencer: a transaction-level model
// (doorbell queue, held request, in-flight record with an age) predicts every
// output each cycle; directed scenarios pin hand-computed values.
module tb_nvme_pcie_req_sequencer;

   localparam int          DEPTH = 8;
   localparam int          TMO   = 16;
   localparam logic [31:0] BASE  = 32'h1000;
   localparam int          DSTRD = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        db_valid = 0, db_is_cq = 0;
   logic [3:0]  db_qid = 0;
   logic [15:0] db_value = 0;
   logic        db_ready, db_error;
   logic [3:0]  db_count;
   logic        reg_req = 0, reg_wr = 0;
   logic [31:0] reg_addr = 0, reg_wdata = 0;
   logic        reg_busy, reg_done, reg_error;
   logic [31:0] reg_rdata;
   logic        pcie_write, pcie_read;
   logic [31:0] pcie_waddr, pcie_wdata, pcie_raddr;
   logic        pcie_wdone = 0, pcie_werror = 0, pcie_rdone = 0, pcie_rerror = 0;
   logic [31:0] pcie_rdata = 0;
   logic        fatal;

   always #5 clk = ~clk;

   nvme_pcie_req_sequencer #(
      .FIFO_DEPTH(DEPTH), .DB_BASE(BASE), .DSTRD(DSTRD), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .axi_aclk(clk), .axi_areset(rst),
      .db_valid(db_valid), .db_ready(db_ready), .db_qid(db_qid), .db_is_cq(db_is_cq),
      .db_value(db_value), .db_count(db_count), .db_error(db_error),
      .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_busy(reg_busy), .reg_done(reg_done), .reg_rdata(reg_rdata), .reg_error(reg_error),
      .pcie_write(pcie_write), .pcie_waddr(pcie_waddr), .pcie_wdata(pcie_wdata),
      .pcie_wdone(pcie_wdone), .pcie_werror(pcie_werror),
      .pcie_read(pcie_read), .pcie_raddr(pcie_raddr), .pcie_rdata(pcie_rdata),
      .pcie_rdone(pcie_rdone), .pcie_rerror(pcie_rerror), .fatal(fatal)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } db_t;

   db_t         q[$];
   bit          m_halt = 0;
   bit          m_inflight = 0;
   bit          x_reg = 0, x_wr = 0;
   logic [31:0] x_addr = 0, x_data = 0;
   int          x_age = 0;
   bit          rq_pend = 0, rq_wr = 0;
   logic [31:0] rq_addr = 0, rq_wdata = 0;
   bit          e_reg_done = 0, e_reg_err = 0, e_rd_valid = 0, e_db_err = 0;
   logic [31:0] e_rdata = 0;

   function automatic logic [31:0] db_addr(input int qid, input int cq);
      return BASE + 32'((2 * qid + cq) << (2 + DSTRD));
   endfunction

   function automatic void model_reset();
      q.delete();
      m_halt = 0; m_inflight = 0; x_reg = 0; x_wr = 0; x_age = 0;
      rq_pend = 0; e_reg_done = 0; e_reg_err = 0; e_rd_valid = 0; e_db_err = 0;
      e_rdata = 0;
   endfunction

   function automatic void model_step();
      bit halted0 = m_halt;
      bit busy0   = rq_pend || (m_inflight && x_reg) || e_reg_done;
      int size0   = q.size();
      bit n_done = 0, n_err = 0, n_rdv = 0, n_dberr = 0;
      db_t d;
      if (halted0) begin
         if (rq_pend) begin
            n_done = 1; n_err = 1; rq_pend = 0;
         end else if (reg_req && !busy0) begin
            n_done = 1; n_err = 1;
         end
      end else begin
         if (m_inflight) begin
            if (x_age == 0) x_age = 1;
            else if (x_wr ? pcie_wdone : pcie_rdone) begin
               m_inflight = 0;
               if (x_reg) begin
                  n_done = 1;
                  n_err  = x_wr ? pcie_werror : pcie_rerror;
                  if (!x_wr) begin
                     e_rdata = pcie_rdata;
                     n_rdv   = 1;
                  end
               end else n_dberr = pcie_werror;
            end else begin
               x_age++;
               if (x_age == TMO) begin
                  m_halt = 1; m_inflight = 0;
                  if (x_reg) rq_pend = 1;
               end
            end
         end else if (rq_pend) begin
            m_inflight = 1; x_reg = 1; x_wr = rq_wr; x_addr = rq_addr;
            x_data = rq_wdata; x_age = 0; rq_pend = 0;
         end else if (size0 != 0) begin
            d = q.pop_front();
            m_inflight = 1; x_reg = 0; x_wr = 1; x_addr = d.addr;
            x_data = d.data; x_age = 0;
         end
         if (reg_req && !busy0) begin
            rq_pend = 1; rq_wr = reg_wr; rq_addr = reg_addr; rq_wdata = reg_wdata;
         end
         if (db_valid && size0 < DEPTH)
            q.push_back('{addr: db_addr(int'(db_qid), int'(db_is_cq)), data: {16'h0, db_value}});
      end
      e_reg_done = n_done;
      if (n_done) begin
         e_reg_err  = n_err;
         e_rd_valid = n_rdv;
      end
      e_db_err = n_dberr;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      bit ew, er;
      @(negedge clk);
      #1;
      ew = m_inflight && x_age == 0 && x_wr;
      er = m_inflight && x_age == 0 && !x_wr;
      check("db_ready", db_ready, !rst && q.size() < DEPTH && !m_halt);
      check("db_count", db_count, q.size());
      check("db_error", db_error, e_db_err);
      check("reg_busy", reg_busy, rq_pend || (m_inflight && x_reg) || e_reg_done);
      check("reg_done", reg_done, e_reg_done);
      if (e_reg_done) check("reg_error", reg_error, e_reg_err);
      if (e_reg_done && e_rd_valid) check("reg_rdata", reg_rdata, e_rdata);
      check("pcie_write", pcie_write, ew);
      check("pcie_read", pcie_read, er);
      if (ew) begin
         check("pcie_waddr", pcie_waddr, x_addr);
         check("pcie_wdata", pcie_wdata, x_data);
      end
      if (er) check("pcie_raddr", pcie_raddr, x_addr);
      check("fatal", fatal, m_halt);
   end

   // Log of issued write addresses for the ordering scenario.
   logic [31:0] wlog[$];
   initial forever begin
      @(negedge clk);
      #1;
      if (pcie_write) wlog.push_back(pcie_waddr);
   end

   // ---------------- PCIe master responder ----------------
   // mode 0: random latency 1..8, random errors; 1: fixed latency; 2: stall.
   int          mode = 1;
   int          fixed_lat = 5;
   logic [31:0] fixed_rdata = 32'hDEADBEEF;
   bit          force_werr = 0;
   bit          spur_en = 0;
   bit          kick = 0;
   int          m_cnt = 0;
   bit          m_is_wr = 0;

   initial forever begin
      @(negedge clk);
      pcie_wdone = 0; pcie_werror = 0; pcie_rdone = 0; pcie_rerror = 0;
      pcie_rdata = $urandom;
      if (kick) begin
         kick = 0;
         pcie_wdone = 1;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            if (m_is_wr) begin
               pcie_wdone  = 1;
               pcie_werror = force_werr || (mode == 0 && $urandom_range(0, 7) == 0);
               force_werr  = 0;
            end else begin
               pcie_rdone  = 1;
               pcie_rerror = (mode == 0 && $urandom_range(0, 7) == 0);
               if (mode != 0) pcie_rdata = fixed_rdata;
            end
         end
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
         if ($urandom_range(0, 1) == 1) begin
            pcie_wdone = 1; pcie_werror = 1'($urandom_range(0, 1));
         end else begin
            pcie_rdone = 1; pcie_rerror = 1'($urandom_range(0, 1));
         end
      end
      if ((pcie_write || pcie_read) && mode != 2) begin
         m_is_wr = pcie_write;
         m_cnt   = (mode == 0) ? $urandom_range(1, 8) : fixed_lat;
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic push_db(input logic [3:0] qid, input logic cq, input logic [15:0] v);
      db_valid = 1; db_qid = qid; db_is_cq = cq; db_value = v;
      @(negedge clk);
      db_valid = 0;
   endtask

   task automatic reg_pulse(input logic wr, input logic [31:0] a, input logic [31:0] d);
      reg_req = 1; reg_wr = wr; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_req = 0;
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit found;
      bit seen;
      int c0;

      // Reset state.
      #1 rst = 1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_db_count", db_count, 0);
      check("rst_db_ready", db_ready, 0);
      check("rst_reg_busy", reg_busy, 0);
      check("rst_pcie_write", pcie_write, 0);
      check("rst_waddr", pcie_waddr, 0);
      check("rst_reg_rdata", reg_rdata, 0);
      check("rst_fatal", fatal, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("post_rst_db_ready", db_ready, 1);

      // 1: single doorbell, done after 5 cycles.
      mode = 1; fixed_lat = 5;
      push_db(4'd3, 1'b0, 16'h0012);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (pcie_write) begin found = 1; break; end
         @(negedge clk);
      end
      check("t1_issued", found, 1);
      check("t1_waddr", pcie_waddr, 32'h1018);
      check("t1_wdata", pcie_wdata, 32'h12);
      seen = 0;
      repeat (10) begin @(negedge clk); seen |= db_error; end
      check("t1_no_db_error", seen, 0);

      // 2: fill FIFO while master stalls, then release one completion.
      mode = 2;
      wlog.delete();
      for (int i = 0; i < 12; i++) begin
         if (!db_ready) break;
         db_valid = 1; db_qid = 4'(i); db_is_cq = 0; db_value = 16'(16'h100 + i);
         @(negedge clk);
      end
      db_valid = 0;
      check("t2_full_count", db_count, 8);
      check("t2_full_ready", db_ready, 0);
      kick = 1;
      mode = 0;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (db_count == 4'd7) begin found = 1; break; end
      end
      check("t2_count7", found, 1);
      check("t2_ready_again", db_ready, 1);
      repeat (150) @(negedge clk);
      check("t2_nwrites", wlog.size(), 9);
      for (int i = 0; i < 9 && i < wlog.size(); i++)
         check("t2_order", wlog[i], 32'(32'h1000 + 8 * i));

      // 3: register read overtakes queued doorbells.
      mode = 1; fixed_lat = 6; fixed_rdata = 32'hDEADBEEF;
      for (int i = 4; i < 8; i++) push_db(4'(i), 1'b1, 16'(i));
      reg_pulse(1'b0, 32'h1C, 32'h0);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (pcie_read) begin found = 1; break; end
         @(negedge clk);
      end
      check("t3_read_issued", found, 1);
      check("t3_raddr", pcie_raddr, 32'h1C);
      check("t3_db_still_queued", db_count, 3);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (reg_done) begin found = 1; break; end
         @(negedge clk);
      end
      check("t3_reg_done", found, 1);
      check("t3_rdata", reg_rdata, 32'hDEADBEEF);
      check("t3_rerror", reg_error, 0);
      repeat (60) @(negedge clk);

      // 4: doorbell werror, next entry still issued.
      mode = 1; fixed_lat = 3; force_werr = 1;
      push_db(4'd1, 1'b0, 16'h0001);
      push_db(4'd2, 1'b0, 16'h0002);
      found = 0;
      for (int i = 0; i < 30; i++) begin
         if (db_error) begin found = 1; break; end
         @(negedge clk);
      end
      check("t4_db_error", found, 1);
      @(negedge clk);
      check("t4_pulse_width", db_error, 0);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (pcie_write) begin found = 1; break; end
         @(negedge clk);
      end
      check("t4_next_issued", found, 1);
      check("t4_next_waddr", pcie_waddr, 32'h1010);
      repeat (20) @(negedge clk);

      // Randomised traffic with spurious completions.
      mode = 0; spur_en = 1;
      repeat (1500) begin
         db_valid  = ($urandom_range(0, 1) == 1);
         db_qid    = 4'($urandom_range(0, 15));
         db_is_cq  = 1'($urandom_range(0, 1));
         db_value  = 16'($urandom);
         reg_req   = ($urandom_range(0, 9) == 0);
         reg_wr    = 1'($urandom_range(0, 1));
         reg_addr  = $urandom & 32'hFFFF_FFFC;
         reg_wdata = $urandom;
         @(negedge clk);
      end
      db_valid = 0; reg_req = 0; spur_en = 0;
      repeat (120) @(negedge clk);

      // 6: reset during WAIT; late completion must be ignored.
      mode = 1; fixed_lat = 5;
      push_db(4'd9, 1'b1, 16'h00AA);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (pcie_write) begin found = 1; break; end
         @(negedge clk);
      end
      check("t6_issued", found, 1);
      repeat (2) @(negedge clk);
      rst = 1;
      #1;
      check("t6_rst_count", db_count, 0);
      check("t6_rst_write", pcie_write, 0);
      check("t6_rst_ready", db_ready, 0);
      @(negedge clk);
      rst = 0;
      seen = 0;
      repeat (8) begin @(negedge clk); seen |= db_error | reg_done; end
      check("t6_no_pulse", seen, 0);

      // 5: timeout halts the block.
      mode = 2;
      push_db(4'd5, 1'b0, 16'h0055);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (pcie_write) begin found = 1; break; end
         @(negedge clk);
      end
      check("t5_issued", found, 1);
      c0 = cyc;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (fatal) begin found = 1; break; end
         @(negedge clk);
      end
      check("t5_fatal", found, 1);
      check("t5_fatal_time", cyc - c0, TMO);
      check("t5_db_ready", db_ready, 0);
      push_db(4'd6, 1'b0, 16'h0066);
      reg_pulse(1'b1, 32'h40, 32'h5);
      check("t5_reg_done", reg_done, 1);
      check("t5_reg_error", reg_error, 1);
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
